// File: rtl/hanoi_move_engine.sv
// rtl/hanoi_move_engine.sv - parametrised Towers-of-Hanoi move/undo engine with history and solved flag
module hanoi_move_engine #(
    parameter int NUMBER_OF_RODS  = 3,
    parameter int NUMBER_OF_DISKS = 4,
    parameter int TARGET_ROD      = 2,
    parameter int HIST_DEPTH      = 8,
    parameter int CNT_W           = 16,
    localparam int ROD_W  = ($clog2(NUMBER_OF_RODS) > 1) ? $clog2(NUMBER_OF_RODS) : 1,
    localparam int DISK_W = $clog2(NUMBER_OF_DISKS + 1),
    localparam int LVL_W  = ($clog2(NUMBER_OF_DISKS) > 1) ? $clog2(NUMBER_OF_DISKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_undo,
    input  logic [ROD_W-1:0]  from_rod,
    input  logic [ROD_W-1:0]  to_rod,
    output logic              resp_valid,
    output logic [2:0]        resp_err,
    output logic [CNT_W-1:0]  move_count,
    output logic              solved,
    input  logic [ROD_W-1:0]  peek_rod,
    input  logic [LVL_W-1:0]  peek_lvl,
    output logic [DISK_W-1:0] peek_disk
);

    localparam int HP_W = ($clog2(HIST_DEPTH) > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int HC_W = $clog2(HIST_DEPTH + 1);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_RANGE   = 3'd1;
    localparam logic [2:0] ERR_SAME    = 3'd2;
    localparam logic [2:0] ERR_EMPTY   = 3'd3;
    localparam logic [2:0] ERR_LARGER  = 3'd4;
    localparam logic [2:0] ERR_NO_HIST = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Game state: one slot per (rod, level), level 0 at the bottom
    logic [DISK_W-1:0] r_slot     [NUMBER_OF_RODS][NUMBER_OF_DISKS];
    logic [DISK_W-1:0] r_height   [NUMBER_OF_RODS];

    // Circular undo history; r_hist_wr points at the next free (or oldest) entry
    logic [ROD_W-1:0]  r_hist_from [HIST_DEPTH];
    logic [ROD_W-1:0]  r_hist_to   [HIST_DEPTH];
    logic [HP_W-1:0]   r_hist_wr;
    logic [HC_W-1:0]   r_hist_cnt;

    // Latched request
    logic              r_undo;
    logic [ROD_W-1:0]  r_from;
    logic [ROD_W-1:0]  r_to;

    logic [2:0]        r_err;
    logic [CNT_W-1:0]  r_count;
    logic              r_solved;

    logic              w_from_ok;
    logic              w_to_ok;
    logic [HP_W-1:0]   w_hist_newest;
    logic [HP_W-1:0]   w_hist_next;
    logic [ROD_W-1:0]  w_src;
    logic [ROD_W-1:0]  w_dst;
    logic [DISK_W-1:0] w_src_h;
    logic [DISK_W-1:0] w_dst_h;
    logic [LVL_W-1:0]  w_src_lvl;
    logic [LVL_W-1:0]  w_dst_top_lvl;
    logic [LVL_W-1:0]  w_dst_lvl;
    logic [DISK_W-1:0] w_src_top;
    logic [DISK_W-1:0] w_dst_top;
    logic [2:0]        w_err;
    logic              w_commit;
    logic [DISK_W-1:0] w_tgt_h_next;

    // Range checks and history pointer arithmetic for the latched request
    always_comb begin
        w_from_ok     = (32'(r_from) < NUMBER_OF_RODS);
        w_to_ok       = (32'(r_to) < NUMBER_OF_RODS);
        w_hist_newest = (r_hist_wr == '0) ? HP_W'(HIST_DEPTH - 1) : (r_hist_wr - 1'b1);
        w_hist_next   = (r_hist_wr == HP_W'(HIST_DEPTH - 1)) ? '0 : (r_hist_wr + 1'b1);
    end

    // Effective source/destination: undo reverses the newest history entry;
    // out-of-range rods are steered to rod 0 so array reads stay in bounds
    always_comb begin
        if (r_undo) begin
            w_src = r_hist_to[w_hist_newest];
            w_dst = r_hist_from[w_hist_newest];
        end else begin
            w_src = w_from_ok ? r_from : '0;
            w_dst = w_to_ok   ? r_to   : '0;
        end
        w_src_h       = r_height[w_src];
        w_dst_h       = r_height[w_dst];
        w_src_lvl     = (w_src_h != '0) ? LVL_W'(w_src_h - 1'b1) : '0;
        w_dst_top_lvl = (w_dst_h != '0) ? LVL_W'(w_dst_h - 1'b1) : '0;
        w_dst_lvl     = LVL_W'(w_dst_h);
        w_src_top     = r_slot[w_src][w_src_lvl];
        w_dst_top     = r_slot[w_dst][w_dst_top_lvl];
    end

    // Legality check, first matching rule wins
    always_comb begin
        w_err = ERR_OK;
        if (r_undo) begin
            if (r_hist_cnt == '0) begin
                w_err = ERR_NO_HIST;
            end
        end else if (!w_from_ok || !w_to_ok) begin
            w_err = ERR_RANGE;
        end else if (r_from == r_to) begin
            w_err = ERR_SAME;
        end else if (w_src_h == '0) begin
            w_err = ERR_EMPTY;
        end else if ((w_dst_h != '0) && (w_src_top > w_dst_top)) begin
            w_err = ERR_LARGER;
        end
        w_commit = (r_state == S_EXEC) && (w_err == ERR_OK);
    end

    // Target rod height after this commit, used to refresh the solved flag
    always_comb begin
        w_tgt_h_next = r_height[TARGET_ROD];
        if (w_commit) begin
            if (w_dst == ROD_W'(TARGET_ROD)) begin
                w_tgt_h_next = r_height[TARGET_ROD] + 1'b1;
            end else if (w_src == ROD_W'(TARGET_ROD)) begin
                w_tgt_h_next = r_height[TARGET_ROD] - 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: one request walks IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: ready only while idle, response pulse only in RESP
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
    end

    // Datapath: latch on accept, commit rods/history/counter on EXEC -> RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUMBER_OF_RODS; r++) begin
                for (int l = 0; l < NUMBER_OF_DISKS; l++) begin
                    r_slot[r][l] <= (r == 0) ? DISK_W'(NUMBER_OF_DISKS - l) : '0;
                end
                r_height[r] <= (r == 0) ? DISK_W'(NUMBER_OF_DISKS) : '0;
            end
            for (int h = 0; h < HIST_DEPTH; h++) begin
                r_hist_from[h] <= '0;
                r_hist_to[h]   <= '0;
            end
            r_hist_wr  <= '0;
            r_hist_cnt <= '0;
            r_undo     <= 1'b0;
            r_from     <= '0;
            r_to       <= '0;
            r_err      <= ERR_OK;
            r_count    <= '0;
            r_solved   <= (TARGET_ROD == 0);
        end else begin
            if ((r_state == S_IDLE) && req_valid) begin
                r_undo <= req_undo;
                r_from <= from_rod;
                r_to   <= to_rod;
            end
            if (r_state == S_EXEC) begin
                r_err    <= w_err;
                r_solved <= (w_tgt_h_next == DISK_W'(NUMBER_OF_DISKS));
                if (w_err == ERR_OK) begin
                    r_slot[w_dst][w_dst_lvl] <= w_src_top;
                    r_slot[w_src][w_src_lvl] <= '0;
                    r_height[w_src]          <= w_src_h - 1'b1;
                    r_height[w_dst]          <= w_dst_h + 1'b1;
                    if (r_undo) begin
                        r_hist_wr  <= w_hist_newest;
                        r_hist_cnt <= r_hist_cnt - 1'b1;
                        if (r_count != '0) begin
                            r_count <= r_count - 1'b1;
                        end
                    end else begin
                        r_hist_from[r_hist_wr] <= r_from;
                        r_hist_to[r_hist_wr]   <= r_to;
                        r_hist_wr              <= w_hist_next;
                        if (r_hist_cnt != HC_W'(HIST_DEPTH)) begin
                            r_hist_cnt <= r_hist_cnt + 1'b1;
                        end
                        if (r_count != {CNT_W{1'b1}}) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Registered status outputs
    always_comb begin
        resp_err   = r_err;
        move_count = r_count;
        solved     = r_solved;
    end

    // Combinational peek into the rod array; 0 outside the board
    always_comb begin
        peek_disk = '0;
        if ((32'(peek_rod) < NUMBER_OF_RODS) && (32'(peek_lvl) < NUMBER_OF_DISKS)) begin
            peek_disk = r_slot[peek_rod][peek_lvl];
        end
    end

endmodule

// File: tb/tb_hanoi_move_engine.sv
// tb/tb_hanoi_move_engine.sv - self-checking bench for hanoi_move_engine
module tb_hanoi_move_engine;

    localparam int R      = 3;
    localparam int N      = 4;
    localparam int HD     = 4;
    localparam int CW     = 16;
    localparam int ROD_W  = 2;
    localparam int DISK_W = 3;
    localparam int LVL_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_undo = 1'b0;
    logic [ROD_W-1:0]  from_rod = '0;
    logic [ROD_W-1:0]  to_rod = '0;
    logic              resp_valid;
    logic [2:0]        resp_err;
    logic [CW-1:0]     move_count;
    logic              solved;
    logic [ROD_W-1:0]  peek_rod = '0;
    logic [LVL_W-1:0]  peek_lvl = '0;
    logic [DISK_W-1:0] peek_disk;

    hanoi_move_engine #(
        .NUMBER_OF_RODS (R),
        .NUMBER_OF_DISKS(N),
        .TARGET_ROD     (2),
        .HIST_DEPTH     (HD),
        .CNT_W          (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_undo  (req_undo),
        .from_rod  (from_rod),
        .to_rod    (to_rod),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .move_count(move_count),
        .solved    (solved),
        .peek_rod  (peek_rod),
        .peek_lvl  (peek_lvl),
        .peek_disk (peek_disk)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_first;
        bit undo;
        int f;
        int t;
        int err;
    } vec_t;

    typedef struct {
        int err;
        int cnt;
        int slv;
    } exp_t;

    int     tests = 0;
    int     fails = 0;
    vec_t   vecs[$];
    exp_t   exp_q[$];
    exp_t   e_cur;

    int     m_rod[R][N];
    int     m_h[R];
    int     m_hf[$];
    int     m_ht[$];
    int     m_cnt;

    int     cyc = 0;
    int     acc_cyc = 0;
    int     prev_acc = 0;
    bit     pend = 1'b0;
    bit     hold_chk = 1'b0;
    int     hold_accepts = 0;
    int     resp_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < R; r++) begin
            for (int l = 0; l < N; l++) m_rod[r][l] = (r == 0) ? N - l : 0;
            m_h[r] = (r == 0) ? N : 0;
        end
        m_hf.delete();
        m_ht.delete();
        m_cnt = 0;
    endfunction

    function automatic void model_move(input int f, input int t);
        m_rod[t][m_h[t]]     = m_rod[f][m_h[f] - 1];
        m_rod[f][m_h[f] - 1] = 0;
        m_h[f]--;
        m_h[t]++;
    endfunction

    function automatic void model_apply(input bit undo, input int f, input int t, input int err);
        int uf;
        int ut;
        if (err != 0) return;
        if (undo) begin
            uf = m_hf.pop_back();
            ut = m_ht.pop_back();
            model_move(ut, uf);
            if (m_cnt > 0) m_cnt--;
        end else begin
            model_move(f, t);
            m_hf.push_back(f);
            m_ht.push_back(t);
            if (m_hf.size() > HD) begin
                void'(m_hf.pop_front());
                void'(m_ht.pop_front());
            end
            m_cnt++;
        end
    endfunction

    function automatic void add(input bit r, input bit u, input int f, input int t, input int e);
        vecs.push_back('{r, u, f, t, e});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency, ready gating and scoreboard comparison on each response
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend && (cyc == acc_cyc + 1)) begin
                check("ready_low_exec", int'(req_ready), 0);
                check("no_resp_in_exec", int'(resp_valid), 0);
            end
            if (resp_valid) begin
                resp_seen++;
                if (!pend || exp_q.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("resp_latency", cyc - acc_cyc, 2);
                    check("ready_low_resp", int'(req_ready), 0);
                    check("resp_err", int'(resp_err), e_cur.err);
                    check("move_count", int'(move_count), e_cur.cnt);
                    check("solved", int'(solved), e_cur.slv);
                end
                pend = 1'b0;
            end else if (pend && (cyc > acc_cyc + 2)) begin
                check("resp_missing", 0, 1);
                pend = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                if (hold_chk && hold_accepts > 0) check("accept_spacing", cyc - prev_acc, 3);
                if (hold_chk) hold_accepts++;
                prev_acc = cyc;
                acc_cyc  = cyc;
                pend     = 1'b1;
            end
        end
    end

    task automatic send(input bit undo, input int f, input int t, input int err,
                        input bit push, input bit hold);
        int g;
        g = 0;
        @(posedge clk); #1;
        while (!req_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (!req_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        req_undo  = undo;
        from_rod  = ROD_W'(f);
        to_rod    = ROD_W'(t);
        req_valid = 1'b1;
        if (push) begin
            model_apply(undo, f, t, err);
            exp_q.push_back('{err, m_cnt, (m_h[2] == N) ? 1 : 0});
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((pend || !req_ready) && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) check("idle_timeout", 0, 1);
    endtask

    task automatic check_state(input string name);
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < N; l++) begin
                peek_rod = ROD_W'(r);
                peek_lvl = LVL_W'(l);
                #1;
                check($sformatf("%s_peek_r%0d_l%0d", name, r, l), int'(peek_disk),
                      (r < R) ? m_rod[r][l] : 0);
            end
        end
        check({name, "_count"}, int'(move_count), m_cnt);
        check({name, "_solved"}, int'(solved), (m_h[2] == N) ? 1 : 0);
    endtask

    task automatic peek_is(input string name, input int r, input int l, input int exp);
        peek_rod = ROD_W'(r);
        peek_lvl = LVL_W'(l);
        #1;
        check(name, int'(peek_disk), exp);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst       = 1'b1;
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int mf[15];
        int mt[15];
        int r0;
        mf = '{0, 0, 1, 0, 2, 2, 0, 0, 1, 1, 2, 1, 0, 0, 1};
        mt = '{1, 2, 2, 1, 0, 1, 1, 2, 2, 0, 0, 2, 1, 2, 2};

        // Undo on empty history, then the optimal 15-move solution
        add(1, 1, 0, 0, 5);
        for (int i = 0; i < 15; i++) add(0, 0, mf[i], mt[i], 0);
        // Illegal move cases
        add(1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 4);
        add(0, 0, 3, 0, 1);
        add(0, 0, 0, 3, 1);
        add(0, 0, 1, 1, 2);
        add(0, 0, 2, 0, 3);
        // Six moves then five undos against a 4-deep history
        add(1, 0, 0, 1, 0);
        add(0, 0, 0, 2, 0);
        add(0, 0, 1, 2, 0);
        add(0, 0, 0, 1, 0);
        add(0, 0, 2, 0, 0);
        add(0, 0, 2, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 5);

        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", int'(req_ready), 1);
        check("reset_resp_valid", int'(resp_valid), 0);
        check("reset_resp_err", int'(resp_err), 0);
        check("reset_count", int'(move_count), 0);
        check("reset_solved", int'(solved), 0);
        check_state("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) do_reset();
            send(vecs[i].undo, vecs[i].f, vecs[i].t, vecs[i].err, 1'b1, 1'b0);
            wait_idle();
            check_state($sformatf("vec%0d", i));
            if (i == 15) begin
                for (int l = 0; l < N; l++) peek_is($sformatf("solved_rod2_l%0d", l), 2, l, N - l);
                check("solved_count15", int'(move_count), 15);
                check("solved_flag", int'(solved), 1);
            end
            if (i == 17) begin
                peek_is("err4_rod0_l3", 0, 3, 0);
                peek_is("err4_rod1_l0", 1, 0, 1);
                check("err4_count", int'(move_count), 1);
            end
            if (i == vecs.size() - 1) check("undo_final_count", int'(move_count), 2);
        end

        // Continuous req_valid: accepts every 3 cycles, nothing lost
        do_reset();
        hold_chk     = 1'b1;
        hold_accepts = 0;
        send(0, 0, 1, 0, 1'b1, 1'b1);
        send(0, 0, 2, 0, 1'b1, 1'b1);
        send(0, 1, 2, 0, 1'b1, 1'b1);
        send(0, 0, 1, 0, 1'b1, 1'b0);
        wait_idle();
        hold_chk = 1'b0;
        check("hold_accepts", hold_accepts, 4);
        check_state("hold");

        // Reset during EXEC aborts the request
        do_reset();
        send(0, 2, 0, 3, 1'b1, 1'b0);
        wait_idle();
        r0 = resp_seen;
        send(0, 0, 2, 0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_resp", resp_seen, r0);
        check("abort_resp_err", int'(resp_err), 0);
        check("abort_ready", int'(req_ready), 1);
        check_state("abort");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
